// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - UART frame loader that writes instruction words into instruction memory
module instr_loader #(
    parameter int INSTR_WIDTH    = 32,
    parameter int INSTR_DEPTH    = 256,
    parameter int TIMEOUT_CYCLES = 50000,
    localparam int AW            = $clog2(INSTR_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   loading,
    output logic                   load_done,
    output logic                   err
);

    localparam int BPW = INSTR_WIDTH / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_CSUM,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]          addr_q;
    logic [7:0]             count_q;
    logic [7:0]             word_cnt;
    logic [BW-1:0]          byte_cnt;
    logic [INSTR_WIDTH-1:0] word_sr;
    logic [7:0]             csum_q;
    logic [TW-1:0]          tmo_cnt;

    logic                   in_frame;
    logic                   timeout_hit;
    logic                   word_done;
    logic                   last_word;
    logic                   csum_ok;
    logic [INSTR_WIDTH-1:0] word_next;

    assign in_frame    = (state == S_ADDR) || (state == S_COUNT) ||
                         (state == S_DATA) || (state == S_CSUM);
    // The counter restarts on every received byte, so only silent cycles count.
    assign timeout_hit = in_frame && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign word_done   = (byte_cnt == BW'(BPW - 1));
    assign last_word   = (word_cnt == count_q - 8'd1);
    assign csum_ok     = (rx_data == csum_q);
    assign word_next   = (word_sr << 8) | INSTR_WIDTH'(rx_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (rx_valid && rx_data == SYNC_BYTE) state_nxt = S_ADDR;
            S_ADDR:  if (timeout_hit) state_nxt = S_IDLE;
                     else if (rx_valid) state_nxt = S_COUNT;
            S_COUNT: if (timeout_hit) state_nxt = S_IDLE;
                     else if (rx_valid) state_nxt = (rx_data != 8'd0) ? S_DATA : S_CSUM;
            S_DATA:  if (timeout_hit) state_nxt = S_IDLE;
                     else if (rx_valid && word_done && last_word) state_nxt = S_CSUM;
            S_CSUM:  if (timeout_hit) state_nxt = S_IDLE;
                     else if (rx_valid) state_nxt = S_RESP;
            S_RESP:  if (tx_valid && tx_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data   <= 8'd0;
            tx_valid  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            loading   <= 1'b0;
            load_done <= 1'b0;
            err       <= 1'b0;
            addr_q    <= '0;
            count_q   <= 8'd0;
            word_cnt  <= 8'd0;
            byte_cnt  <= '0;
            word_sr   <= '0;
            csum_q    <= 8'd0;
            tmo_cnt   <= '0;
        end else begin
            wr_en     <= 1'b0;
            load_done <= 1'b0;
            loading   <= (state_nxt != S_IDLE);

            if (!in_frame || rx_valid) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (timeout_hit) begin
                err      <= 1'b1;
                byte_cnt <= '0;
                word_sr  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            err      <= 1'b0;
                            csum_q   <= 8'd0;
                            byte_cnt <= '0;
                            word_cnt <= 8'd0;
                            word_sr  <= '0;
                        end
                    end
                    S_ADDR: begin
                        if (rx_valid) begin
                            addr_q <= AW'(rx_data);
                            csum_q <= csum_q ^ rx_data;
                        end
                    end
                    S_COUNT: begin
                        if (rx_valid) begin
                            count_q <= rx_data;
                            csum_q  <= csum_q ^ rx_data;
                        end
                    end
                    S_DATA: begin
                        if (rx_valid) begin
                            csum_q  <= csum_q ^ rx_data;
                            word_sr <= word_next;
                            if (word_done) begin
                                byte_cnt <= '0;
                                word_cnt <= word_cnt + 8'd1;
                                wr_en    <= 1'b1;
                                wr_addr  <= addr_q;
                                wr_data  <= word_next;
                                addr_q   <= (addr_q == AW'(INSTR_DEPTH - 1)) ? '0 : addr_q + AW'(1);
                            end else begin
                                byte_cnt <= byte_cnt + BW'(1);
                            end
                        end
                    end
                    S_CSUM: begin
                        if (rx_valid) begin
                            tx_valid  <= 1'b1;
                            tx_data   <= csum_ok ? ACK_BYTE : NAK_BYTE;
                            load_done <= csum_ok;
                            if (!csum_ok) err <= 1'b1;
                        end
                    end
                    S_RESP: begin
                        if (tx_ready) tx_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized scoreboard bench for instr_loader
module tb_instr_loader;

    localparam int IW    = 32;
    localparam int DEPTH = 256;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        loading;
    logic        load_done;
    logic        err;

    instr_loader #(
        .INSTR_WIDTH(IW),
        .INSTR_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .loading(loading),
        .load_done(load_done),
        .err(err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] words[DEPTH];
    bit          hold_ready = 1'b0;
    logic        prev_tv;
    logic [7:0]  tx_cap;
    logic [7:0]  e_tx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every write and response against the queued expectations.
    initial begin
        prev_tv = 1'b0;
        tx_cap  = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_tv = 1'b0;
            end else begin
                if (wr_en) begin
                    if (exp_wa.size() == 0) begin
                        check("unexpected_write", wr_en, 1'b0);
                    end else begin
                        check("wr_addr", wr_addr, exp_wa.pop_front());
                        check("wr_data", wr_data, exp_wd.pop_front());
                    end
                end
                if (tx_valid && !prev_tv) begin
                    if (exp_tx.size() == 0) begin
                        check("unexpected_tx", tx_valid, 1'b0);
                    end else begin
                        e_tx = exp_tx.pop_front();
                        check("tx_data", tx_data, e_tx);
                        check("load_done_on_rise", load_done, e_tx == 8'h06);
                    end
                    tx_cap = tx_data;
                end else begin
                    if (tx_valid) check("tx_data_stable", tx_data, tx_cap);
                    if (load_done) check("load_done_stray", load_done, 1'b0);
                end
                prev_tv = tx_valid;
            end
        end
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Reference model: expected writes at (base+i) mod DEPTH, checksum is XOR of addr, count, data.
    task automatic run_frame(input logic [7:0] base, input int cnt, input logic [7:0] mask);
        logic [7:0] cs;
        cs = base ^ 8'(cnt);
        for (int i = 0; i < cnt; i++) begin
            for (int b = 3; b >= 0; b--) cs = cs ^ words[i][8*b +: 8];
            exp_wa.push_back(8'((int'(base) + i) % DEPTH));
            exp_wd.push_back(words[i]);
        end
        exp_tx.push_back((mask == 8'd0) ? 8'h06 : 8'h15);
        send_byte(8'hA5);
        send_byte(base);
        send_byte(8'(cnt));
        for (int i = 0; i < cnt; i++)
            for (int b = 3; b >= 0; b--) send_byte(words[i][8*b +: 8]);
        send_byte(cs ^ mask);
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!loading && exp_tx.size() == 0 && exp_wa.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    initial begin
        int         c;
        int         cnt;
        logic [7:0] mask;
        bit         seen;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_loading", loading, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_outputs", {tx_data, wr_addr, wr_data, load_done}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        words[0] = 32'h8000_0001;
        words[1] = 32'h4000_0002;
        run_frame(8'h00, 2, 8'h00);
        wait_done("ack_frame_done");
        check("ack_frame_err", err, 1'b0);

        run_frame(8'h00, 2, 8'hC0);
        wait_done("nak_frame_done");
        check("nak_frame_err", err, 1'b1);
        exp_tx.push_back(8'h06);
        send_byte(8'hA5);
        check("sync_clears_err", err, 1'b0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_done("after_nak_frame_done");

        words[0] = 32'h0010_0000;
        words[1] = 32'h0C00_0001;
        run_frame(8'hFF, 2, 8'h00);
        wait_done("wrap_frame_done");

        run_frame(8'h05, 0, 8'h00);
        wait_done("zero_count_done");
        check("zero_count_err", err, 1'b0);

        hold_ready  = 1'b1;
        words[0]    = 32'hDEAD_BEEF;
        run_frame(8'h20, 1, 8'h00);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("hold_tx_seen", seen, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("hold_tx_valid", tx_valid, 1'b1);
            rx_data  = 8'hA5;
            rx_valid = (i == 3 || i == 6);
            @(negedge clk);
        end
        rx_valid   = 1'b0;
        hold_ready = 1'b0;
        wait_done("hold_done");
        repeat (3) @(negedge clk);
        check("hold_dropped_bytes", loading, 1'b0);

        for (int f = 0; f < 25; f++) begin
            cnt  = $urandom_range(0, 6);
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            for (int i = 0; i < cnt; i++) words[i] = $urandom;
            run_frame(8'($urandom_range(0, 255)), cnt, mask);
            wait_done("rand_frame_done");
            check("rand_frame_err", err, mask != 8'd0);
        end

        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h03);
        @(negedge clk);
        rx_data  = 8'h12;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_data  = 8'h34;
        @(negedge clk);
        rx_valid = 1'b0;
        c = 0;
        while (loading && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("timeout_cycles", (c >= 95 && c <= 105), 1'b1);
        check("timeout_err", err, 1'b1);
        repeat (5) @(negedge clk);
        check("timeout_no_tx", tx_valid, 1'b0);

        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'h66);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_loading", loading, 1'b0);
        check("midrst_outputs", {tx_valid, wr_en, load_done, err, tx_data, wr_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        words[0] = 32'hCAFE_0123;
        run_frame(8'h10, 1, 8'h00);
        wait_done("post_reset_frame_done");
        check("post_reset_err", err, 1'b0);

        check("queues_empty", exp_tx.size() + exp_wa.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
